// File: rtl/div4_seq.sv
// div4_seq: sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero returns all-ones quotient, the dividend as remainder, and flags div_zero.
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d, rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic [WIDTH+1:0] sh, diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        sh      = {rem_q, dvd_q[WIDTH-1]};
        diff    = sh - {2'b00, dsr_q};
        case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = dividend;
                    dz_d    = 1'b1;
                end else if (start) begin
                    state_d = CALC;
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    dz_d    = 1'b0;
                end
            end
            CALC: begin
                // negative trial difference means restore the shifted remainder
                rem_d = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = dvd_d;
                    rmd_d   = rem_d[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_div4_seq.sv
// tb_div4_seq: randomized and directed checks of div4_seq against a cycle-count reference model.
module tb_div4_seq;
    localparam int W = 4;

    logic         clk = 0, rst_n = 1, start = 0;
    logic [W-1:0] dividend = 0, divisor = 0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;
    int           tests = 0, fails = 0;

    div4_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: cycles left in the busy window; results publish when done becomes due
    int           m_left;
    logic [W-1:0] p_q, p_r, e_q, e_r;
    logic         e_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; e_q = 0; e_r = 0; e_z = 0;
        end else if (m_left == 0 && start) begin
            if (divisor == 0) begin
                m_left = 1; e_q = '1; e_r = dividend; e_z = 1;
            end else begin
                m_left = W + 1; e_z = 0;
                p_q = dividend / divisor; p_r = dividend % divisor;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin e_q = p_q; e_r = p_r; end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_left == 1);
            chk("quotient", quotient, e_q);
            chk("remainder", remainder, e_r);
            chk("div_zero", div_zero, e_z);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, b, eq, er, input logic ez, input int lat);
        int n;
        wait_idle();
        @(negedge clk);
        start = 1; dividend = a; divisor = b;
        @(negedge clk);
        start = 0;
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk("latency", n, lat);
        chk("lit_q", quotient, eq);
        chk("lit_r", remainder, er);
        chk("lit_dz", div_zero, ez);
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        do_op(13, 3, 4, 1, 0, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_q", quotient, 4);
            chk("hold_r", remainder, 1);
        end
        do_op(15, 1, 15, 0, 0, 5);
        do_op(7, 9, 0, 7, 0, 5);
        do_op(0, 5, 0, 0, 0, 5);
        do_op(15, 15, 1, 0, 0, 5);
        do_op(9, 0, 15, 9, 1, 1);
        do_op(6, 2, 3, 0, 0, 5);

        begin
            int last = -1, pulses = 0;
            wait_idle();
            @(negedge clk);
            start = 1; dividend = 13; divisor = 3;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 2) begin dividend = 2; divisor = 2; end
                if (done) begin
                    chk("pulse_q", quotient, pulses == 0 ? 4 : 1);
                    chk("pulse_r", remainder, pulses == 0 ? 1 : 0);
                    if (last >= 0) chk("pulse_period", i - last, 6);
                    last = i; pulses++;
                end
            end
            chk("pulse_count", pulses, 3);
            start = 0;
        end

        wait_idle();
        @(negedge clk);
        start = 1; dividend = 14; divisor = 3;
        @(negedge clk);
        start = 0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 0);
        end
        do_op(14, 3, 4, 2, 0, 5);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_op(W'(a), W'(b), b == 0 ? W'(15) : W'(a / b), b == 0 ? W'(a) : W'(a % b),
                      b == 0, b == 0 ? 1 : 5);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start    = $urandom_range(0, 2) == 0;
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        start = 0;
        wait_idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
